ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 5-stage RV32I pipeline. It sits between the ID/EX and EX/MEM boundaries. It takes decoded operands and control from the ID/EX registers and selects forwarded operands. It runs the ALU, resolves conditional branches for the fetch stage, and registers all results into the EX/MEM pipeline register with stall and flush support.

Parameters:
XLEN, 32, datapath width.
REG_ADDR_W, 5, register index width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
stall_i  input  1  hold EX/MEM register contents.
flush_i  input  1  load a bubble into EX/MEM.
RegWrite_i, MemRead_i, MemWrite_i, Branch_i, ALUSrc_i, MemToReg_i  input  1 each  control from ID/EX.
ALUOp_i  input  2  00=add, 01=branch compare, 10=funct decode.
funct3_i  input  3  instr[14:12].
funct7b5_i  input  1  instr[30].
rs1_data_i, rs2_data_i, imm_i, pc4_i  input  XLEN each  ID/EX data.
rd_addr_i  input  REG_ADDR_W  destination register.
fwd_a_sel_i, fwd_b_sel_i  input  2 each  00=ID/EX, 01=WB data, 10=MEM data, 11=ID/EX.
mem_fwd_data_i, wb_fwd_data_i  input  XLEN each  forwarding sources.
branch_taken_o  output  1  combinational, to IF.
branch_target_o  output  XLEN  combinational, (pc4_i-4)+imm_i.
RegWrite_o, MemRead_o, MemWrite_o, MemToReg_o  output  1 each  registered.
alu_result_o, store_data_o  output  XLEN each  registered.
rd_addr_o  output  REG_ADDR_W  registered.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge.
- Operand A: forwarded rs1 selected by fwd_a_sel_i.
- Forwarded B: forwarded rs2 selected by fwd_b_sel_i.
- Operand B: imm_i if ALUSrc_i=1, else forwarded B.
- store_data: always forwarded B, never the immediate.
- ALUOp=00: A+B.
- ALUOp=01: A-B; flags are eq, signed lt, unsigned lt.
- ALUOp=10, arithmetic by funct3:
  - 000: SUB if funct7b5&~ALUSrc, else ADD.
  - 001: SLL.
  - 010: SLT (signed), result is 0 or 1.
  - 011: SLTU, result is 0 or 1.
  - 100: XOR.
  - 101: SRA if funct7b5, else SRL.
  - 110: OR.
  - 111: AND.
- Shifts use B[4:0] only.
- ALUOp=11: result 0.
- All arithmetic wraps modulo 2^XLEN; no overflow flag.
- branch_taken_o = Branch_i & cond, where cond by funct3 is:
  - 000 eq, 001 ~eq, 100 lt, 101 ~lt, 110 ltu, 111 ~ltu.
  - 010 and 011 give cond 0.
- branch_target_o is always driven, even when no branch is taken.
- branch_taken_o is not gated by stall_i or flush_i; the hazard unit owns flushing the younger stages.
- EX/MEM register update each rising edge, in priority order:
  1. reset: all registered outputs are 0.
  2. flush_i: the four control outputs go to 0 (bubble); data outputs may take any value but must be deterministic; implement them as cleared.
  3. stall_i: all registered outputs hold.
  4. Otherwise: capture RegWrite, MemRead, MemWrite, MemToReg, alu_result, store_data and rd_addr.
- Latency: one cycle from ID/EX inputs to registered outputs.
- A write to x0 is passed through unchanged; regfile masks it.
- Simultaneous flush_i and stall_i: flush wins.
- Reset held mid-stall: outputs clear and stay 0 until reset deasserts.
- First load occurs on the edge after reset drops.

Test Plan:
- Reset: assert reset 2 cycles with nonzero inputs -> all registered outputs 0; release, ADD 5+7 -> alu_result_o=12 one edge later.
- R-type ALU: A=0xFFFFFFF0, B=4, ALUOp=10, walk funct3 0..7 with funct7b5 set where legal -> results:
  - SUB=0xFFFFFFEC
  - SLL=0xFFFFFF00
  - SLT=1, SLTU=0
  - XOR=0xFFFFFFF4
  - SRA=0xFFFFFFFF, SRL=0x0FFFFFFF
  - OR=0xFFFFFFF4, AND=0
- I-type: ADDI with funct7b5=1, ALUSrc=1, A=10, imm=3 -> 13, not SUB.
- Forwarding: rs1_data=1, mem_fwd=100, wb_fwd=50:
  - fwd_a=10 -> A=100, ADD with B=1 gives 101.
  - fwd_a=01 -> 51.
  - store with fwd_b=10 -> store_data_o=100.
- Branch: pc4=0x104, imm=0xFFFFFFF8:
  - BLT, A=-1, B=1 -> taken=1, target=0xF8.
  - BLTU, same operands -> taken=0.
  - BEQ, equal operands, Branch_i=0 -> taken=0.
- Stall/flush: load LW control, then stall_i 3 cycles with changing inputs -> outputs held. Then stall_i=flush_i=1 -> MemRead_o=RegWrite_o=0 next edge.

Source files
------------

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage: operand forwarding, ALU, branch resolve, EX/MEM register
// Branch outputs are combinational toward IF; everything else is captured into EX/MEM.
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  RegWrite_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  Branch_i,
    input  logic                  ALUSrc_i,
    input  logic                  MemToReg_i,
    input  logic [1:0]            ALUOp_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7b5_i,
    input  logic [XLEN-1:0]       rs1_data_i,
    input  logic [XLEN-1:0]       rs2_data_i,
    input  logic [XLEN-1:0]       imm_i,
    input  logic [XLEN-1:0]       pc4_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [1:0]            fwd_a_sel_i,
    input  logic [1:0]            fwd_b_sel_i,
    input  logic [XLEN-1:0]       mem_fwd_data_i,
    input  logic [XLEN-1:0]       wb_fwd_data_i,
    output logic                  branch_taken_o,
    output logic [XLEN-1:0]       branch_target_o,
    output logic                  RegWrite_o,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic                  MemToReg_o,
    output logic [XLEN-1:0]       alu_result_o,
    output logic [XLEN-1:0]       store_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] diff;
    logic [4:0]      shamt;
    logic            eq;
    logic            lt;
    logic            ltu;
    logic            cond;
    logic [XLEN-1:0] alu_res;

    always_comb begin
        case (fwd_a_sel_i)
            2'b01:   op_a = wb_fwd_data_i;
            2'b10:   op_a = mem_fwd_data_i;
            default: op_a = rs1_data_i;
        endcase
        case (fwd_b_sel_i)
            2'b01:   fwd_b = wb_fwd_data_i;
            2'b10:   fwd_b = mem_fwd_data_i;
            default: fwd_b = rs2_data_i;
        endcase
    end

    assign op_b  = ALUSrc_i ? imm_i : fwd_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[4:0];
    assign eq    = (op_a == op_b);
    assign lt    = ($signed(op_a) < $signed(op_b));
    assign ltu   = (op_a < op_b);

    always_comb begin
        alu_res = '0;
        case (ALUOp_i)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = diff;
            2'b10: begin
                case (funct3_i)
                    // funct7b5 also appears in I-type immediates, so only R-type may subtract
                    3'b000:  alu_res = (funct7b5_i && !ALUSrc_i) ? diff : (op_a + op_b);
                    3'b001:  alu_res = op_a << shamt;
                    3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt};
                    3'b011:  alu_res = {{(XLEN-1){1'b0}}, ltu};
                    3'b100:  alu_res = op_a ^ op_b;
                    3'b101:  alu_res = funct7b5_i ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
                    3'b110:  alu_res = op_a | op_b;
                    default: alu_res = op_a & op_b;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (funct3_i)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    // Not gated by stall/flush: the hazard unit squashes younger stages itself
    assign branch_taken_o  = Branch_i & cond;
    assign branch_target_o = (pc4_i - XLEN'(4)) + imm_i;

    logic                  reg_write_q, reg_write_d;
    logic                  mem_read_q,  mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [XLEN-1:0]       alu_result_q, alu_result_d;
    logic [XLEN-1:0]       store_data_q, store_data_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;

    always_comb begin
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        rd_addr_d    = rd_addr_q;
        if (flush_i) begin
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            alu_result_d = '0;
            store_data_d = '0;
            rd_addr_d    = '0;
        end else if (!stall_i) begin
            reg_write_d  = RegWrite_i;
            mem_read_d   = MemRead_i;
            mem_write_d  = MemWrite_i;
            mem_to_reg_d = MemToReg_i;
            alu_result_d = alu_res;
            store_data_d = fwd_b;
            rd_addr_d    = rd_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_addr_q    <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    assign RegWrite_o   = reg_write_q;
    assign MemRead_o    = mem_read_q;
    assign MemWrite_o   = mem_write_q;
    assign MemToReg_o   = mem_to_reg_q;
    assign alu_result_o = alu_result_q;
    assign store_data_o = store_data_q;
    assign rd_addr_o    = rd_addr_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with directed vectors
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        rw_i, mr_i, mw_i, br_i, alusrc_i, mtr_i;
    logic [1:0]  aluop_i;
    logic [2:0]  f3_i;
    logic        f7_i;
    logic [31:0] rs1_i, rs2_i, imm_i, pc4_i;
    logic [4:0]  rd_i;
    logic [1:0]  fa_i, fb_i;
    logic [31:0] memf_i, wbf_i;
    logic        bt_o;
    logic [31:0] tgt_o;
    logic        rw_o, mr_o, mw_o, mtr_o;
    logic [31:0] alu_o, st_o;
    logic [4:0]  rd_o;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
        .RegWrite_i(rw_i), .MemRead_i(mr_i), .MemWrite_i(mw_i), .Branch_i(br_i),
        .ALUSrc_i(alusrc_i), .MemToReg_i(mtr_i), .ALUOp_i(aluop_i),
        .funct3_i(f3_i), .funct7b5_i(f7_i),
        .rs1_data_i(rs1_i), .rs2_data_i(rs2_i), .imm_i(imm_i), .pc4_i(pc4_i),
        .rd_addr_i(rd_i), .fwd_a_sel_i(fa_i), .fwd_b_sel_i(fb_i),
        .mem_fwd_data_i(memf_i), .wb_fwd_data_i(wbf_i),
        .branch_taken_o(bt_o), .branch_target_o(tgt_o),
        .RegWrite_o(rw_o), .MemRead_o(mr_o), .MemWrite_o(mw_o), .MemToReg_o(mtr_o),
        .alu_result_o(alu_o), .store_data_o(st_o), .rd_addr_o(rd_o)
    );

    typedef struct {
        string       name;
        logic        rw, mr, mw, mtr;
        logic [31:0] alu, st;
        logic [4:0]  rd;
        bit          chk_data;
        bit          chk_br;
        logic        bt;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t c;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                c = q.pop_front();
                check({c.name, ".RegWrite"}, 32'(rw_o),  32'(c.rw));
                check({c.name, ".MemRead"},  32'(mr_o),  32'(c.mr));
                check({c.name, ".MemWrite"}, 32'(mw_o),  32'(c.mw));
                check({c.name, ".MemToReg"}, 32'(mtr_o), 32'(c.mtr));
                if (c.chk_data) begin
                    check({c.name, ".alu"},   alu_o,      c.alu);
                    check({c.name, ".store"}, st_o,       c.st);
                    check({c.name, ".rd"},    32'(rd_o),  32'(c.rd));
                end
                if (c.chk_br) begin
                    check({c.name, ".taken"},  32'(bt_o), 32'(c.bt));
                    check({c.name, ".target"}, tgt_o,     c.tgt);
                end
            end
        end
    end

    task automatic idle();
        reset = 0; stall = 0; flush = 0;
        rw_i = 0; mr_i = 0; mw_i = 0; br_i = 0; alusrc_i = 0; mtr_i = 0;
        aluop_i = 2'b00; f3_i = 3'b000; f7_i = 0;
        rs1_i = '0; rs2_i = '0; imm_i = '0; pc4_i = '0; rd_i = '0;
        fa_i = 2'b00; fb_i = 2'b00; memf_i = '0; wbf_i = '0;
    endtask

    task automatic expect_out(input string n, input logic rw, input logic mr, input logic mw,
                              input logic mtr, input logic [31:0] alu, input logic [31:0] st,
                              input logic [4:0] rd);
        e.name = n; e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr;
        e.alu = alu; e.st = st; e.rd = rd;
        e.chk_data = 1; e.chk_br = 0; e.bt = 0; e.tgt = '0;
    endtask

    task automatic rtype(input string n, input logic [2:0] f3, input logic f7, input logic [31:0] res);
        @(negedge clk); idle();
        rw_i = 1; aluop_i = 2'b10; f3_i = f3; f7_i = f7;
        rs1_i = 32'hFFFF_FFF0; rs2_i = 32'd4; rd_i = 5'd10;
        expect_out(n, 1, 0, 0, 0, res, 32'd4, 5'd10); q.push_back(e);
    endtask

    task automatic branch(input string n, input logic b, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] bb, input logic taken);
        @(negedge clk); idle();
        br_i = b; aluop_i = 2'b01; f3_i = f3; rs1_i = a; rs2_i = bb;
        pc4_i = 32'h104; imm_i = 32'hFFFF_FFF8;
        expect_out(n, 0, 0, 0, 0, a - bb, bb, 5'd0);
        e.chk_br = 1; e.bt = taken; e.tgt = 32'h0000_00F8; q.push_back(e);
    endtask

    initial begin : stim
        idle();
        reset = 1;
        // Reset with live inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); reset = 1;
            rw_i = 1; mr_i = 1; mtr_i = 1; rs1_i = 5; rs2_i = 7; rd_i = 5'd3;
            expect_out("reset", 0, 0, 0, 0, 0, 0, 0); q.push_back(e);
        end
        @(negedge clk); idle();
        rw_i = 1; rs1_i = 5; rs2_i = 7; rd_i = 5'd3;
        expect_out("add_first", 1, 0, 0, 0, 32'd12, 32'd7, 5'd3); q.push_back(e);

        rtype("sub",  3'b000, 1, 32'hFFFF_FFEC);
        rtype("sll",  3'b001, 0, 32'hFFFF_FF00);
        rtype("slt",  3'b010, 0, 32'd1);
        rtype("sltu", 3'b011, 0, 32'd0);
        rtype("xor",  3'b100, 0, 32'hFFFF_FFF4);
        rtype("sra",  3'b101, 1, 32'hFFFF_FFFF);
        rtype("srl",  3'b101, 0, 32'h0FFF_FFFF);
        rtype("or",   3'b110, 0, 32'hFFFF_FFF4);
        rtype("and",  3'b111, 0, 32'd0);

        // ADDI with instr[30] set must still add; store data ignores immediate
        @(negedge clk); idle();
        rw_i = 1; aluop_i = 2'b10; f3_i = 3'b000; f7_i = 1; alusrc_i = 1;
        rs1_i = 10; imm_i = 3; rs2_i = 99; rd_i = 5'd6;
        expect_out("addi", 1, 0, 0, 0, 32'd13, 32'd99, 5'd6); q.push_back(e);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            rw_i = 1; rs1_i = 1; rs2_i = 1; memf_i = 100; wbf_i = 50; rd_i = 5'd2;
            fa_i = (i == 0) ? 2'b10 : (i == 1) ? 2'b01 : 2'b11;
            expect_out((i == 0) ? "fwd_mem" : (i == 1) ? "fwd_wb" : "fwd_11", 1, 0, 0, 0,
                       (i == 0) ? 32'd101 : (i == 1) ? 32'd51 : 32'd2, 32'd1, 5'd2);
            q.push_back(e);
        end

        @(negedge clk); idle();
        mw_i = 1; alusrc_i = 1; rs1_i = 1; imm_i = 8; rs2_i = 1;
        memf_i = 100; wbf_i = 50; fb_i = 2'b10;
        expect_out("store_fwd", 0, 0, 1, 0, 32'd9, 32'd100, 5'd0); q.push_back(e);

        branch("blt",       1, 3'b100, 32'hFFFF_FFFF, 32'd1, 1);
        branch("bltu",      1, 3'b110, 32'hFFFF_FFFF, 32'd1, 0);
        branch("bge",       1, 3'b101, 32'hFFFF_FFFF, 32'd1, 0);
        branch("beq_nobr",  0, 3'b000, 32'd5, 32'd5, 0);
        branch("beq",       1, 3'b000, 32'd5, 32'd5, 1);
        branch("bne",       1, 3'b001, 32'd5, 32'd5, 0);
        branch("f3_010",    1, 3'b010, 32'd1, 32'd5, 0);

        @(negedge clk); idle();
        rw_i = 1; rd_i = 5'd0; rs1_i = 3; rs2_i = 4;
        expect_out("x0_write", 1, 0, 0, 0, 32'd7, 32'd4, 5'd0); q.push_back(e);

        // LW, then stall while inputs change
        @(negedge clk); idle();
        rw_i = 1; mr_i = 1; mtr_i = 1; alusrc_i = 1; rs1_i = 32'h1000; imm_i = 4;
        rs2_i = 32'h55; rd_i = 5'd7;
        expect_out("lw", 1, 1, 0, 1, 32'h1004, 32'h55, 5'd7); q.push_back(e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); stall = 1;
            mw_i = 1; rs1_i = 32'(i * 17 + 1); rs2_i = 32'(i + 9); rd_i = 5'(i + 20);
            expect_out("stall_hold", 1, 1, 0, 1, 32'h1004, 32'h55, 5'd7); q.push_back(e);
        end
        @(negedge clk); idle(); stall = 1; flush = 1;
        rw_i = 1; mr_i = 1; rs1_i = 8;
        expect_out("stall_flush", 0, 0, 0, 0, 0, 0, 0); e.chk_data = 0; q.push_back(e);

        // Reset held during a stall clears and holds zero
        @(negedge clk); idle();
        rw_i = 1; rs1_i = 1; rs2_i = 2; rd_i = 5'd9;
        expect_out("pre_rst", 1, 0, 0, 0, 32'd3, 32'd2, 5'd9); q.push_back(e);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); stall = 1; reset = 1; rw_i = 1; rs1_i = 4;
            expect_out("rst_stall", 0, 0, 0, 0, 0, 0, 0); q.push_back(e);
        end
        @(negedge clk); idle(); stall = 1; rw_i = 1; rs1_i = 4; rd_i = 5'd1;
        expect_out("post_rst_stall", 0, 0, 0, 0, 0, 0, 0); q.push_back(e);

        @(negedge clk); idle();
        rw_i = 1; aluop_i = 2'b11; rs1_i = 7; rs2_i = 6; rd_i = 5'd4;
        expect_out("aluop11", 1, 0, 0, 0, 32'd0, 32'd6, 5'd4); q.push_back(e);

        @(negedge clk); idle();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
